fuzz_response_checker: RTL and testbench
========================================

# fuzz_response_checker

Self-checking response end of the fuzz simulation flow. The stimulus side applies one input vector per clock to the design under test. This block consumes the `y` output of the synthesized netlist alongside the `y` of the golden RTL model, one sample per accepted cycle. It counts mismatches, records the first failing vector index and folds every DUT response into a 32-bit signature, so that a run reduces to a registered pass/fail verdict instead of a post-processed `$strobe` log.

## Interface
Parameters:
- `Y_W`, 635: width of the compared `y` bus (`[634:0]`).
- `VEC_CNT`, 21: number of samples per run.
- `CNT_W`, 16: width of the index and counter outputs; must hold `VEC_CNT`.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `start`, in, 1: begins a run when in IDLE or DONE.
- `sample_valid`, in, 1: `y_ref`/`y_dut` hold a sample this cycle.
- `y_ref`, in, `Y_W`: golden-model response.
- `y_dut`, in, `Y_W`: netlist response.
- `busy`, out, 1: run in progress (RUN state).
- `done`, out, 1: run complete; held until the next `start` or `rst`.
- `pass`, out, 1: `done` and `mismatch_cnt == 0`.
- `mismatch_cnt`, out, `CNT_W`: number of mismatching samples; saturates at all-ones.
- `first_fail_idx`, out, `CNT_W`: index (0-based) of the first mismatching sample; all-ones if there is none.
- `signature`, out, 32: running CRC of the DUT responses.

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE, `start` = 1 → RUN. On entry:
  - `idx`, `mismatch_cnt` ← 0
  - `first_fail_idx` ← all-ones
  - `signature` ← 0xFFFFFFFF
  - `done`, `pass` ← 0
- RUN, `sample_valid` = 1, for each accepted sample:
  - mismatch is `y_ref != y_dut`, a full-width compare; X/Z is never produced by the bench.
  - On mismatch, `mismatch_cnt` increments (saturating at all-ones).
  - If `first_fail_idx` is still all-ones, it takes the current `idx`.
  - `signature` updates; `idx` increments.
- RUN, sample with `idx == VEC_CNT-1` accepted → DONE.
- RUN, `start` is ignored. Cycles with `sample_valid` = 0 leave all state unchanged.
- DONE, `sample_valid` is ignored.
- Signature step:
  - fold = XOR of the 32-bit chunks of `y_dut`, zero-padded at the MSB end to a multiple of 32.
  - `signature` ← crc32_step(`signature` ^ fold): 32 MSB-first shift iterations, polynomial 0x04C11DB7, no reflection, no final XOR.
- Reset values:
  - `busy`, `done`, `pass`, `mismatch_cnt` = 0
  - `first_fail_idx` = all-ones
  - `signature` = 0xFFFFFFFF
  - state = IDLE
- Reset mid-run aborts the run; partial results are discarded.

## Timing
- All outputs are registered.
- A sample accepted on edge N is reflected in `mismatch_cnt`, `first_fail_idx` and `signature` after edge N.
- The final sample's edge sets `done` = 1 and `busy` = 0 together; `pass` is valid in the same cycle.
- `start` on edge N: `busy` = 1 after edge N. A `sample_valid` in that same cycle is not accepted; the first sample can be taken on edge N+1.
- `start` in DONE restarts the run in one cycle, with no IDLE pass.
- Throughput is one sample per clock with no back-pressure. The bench drives at most one sample per clock.

## Configuration
- `FUZZ_CHK_SIGNATURE_EN` defined: fold, CRC logic and the signature register are built as described above.
- Not defined: `signature` is tied to 32'h0 and no fold or CRC logic is synthesized. Compare, counting and the FSM are unchanged.

## Structure
- Package `fuzz_chk_pkg` holds:
  - the state enum (IDLE/RUN/DONE)
  - `CRC32_POLY` = 32'h04C11DB7
  - `CRC32_INIT` = 32'hFFFFFFFF
  - `SIG_W` = 32
- Sub-module `fuzz_crc32_step`: purely combinational, 32-bit state in, 32-bit state out. Instantiated only under `FUZZ_CHK_SIGNATURE_EN`.
- The XOR fold is a generate loop in the top; it contains no separate storage.

## Test plan
- **Reset:** `rst` = 1 mid-simulation → next cycle `busy`=0, `done`=0, `pass`=0, `mismatch_cnt`=0, `first_fail_idx`=16'hFFFF, `signature`=32'hFFFFFFFF.
- **Clean run:** `start`, then 21 back-to-back samples with `y_ref == y_dut` (the bench's 21 vectors) → `done`=1 after the 21st edge, `pass`=1, `mismatch_cnt`=0, `first_fail_idx`=16'hFFFF.
- **Two mismatches:** bit 634 flipped in `y_dut` on samples 3 and 7 → `mismatch_cnt`=2, `first_fail_idx`=3, `pass`=0.
- **Gaps and ignored start:** `sample_valid` low for 4 cycles between samples 10 and 11, and `start` pulsed during RUN → still exactly 21 samples counted; `done` arrives 4 cycles later than in the clean run.
- **Reset mid-run:** `rst` after 5 samples, then `start` plus 21 clean samples → `pass`=1, `mismatch_cnt`=0.
- **Signature:** `VEC_CNT`=1, `y_dut` = 32'hFFFFFFFF in bits [31:0] and 0 elsewhere → `signature`=32'h00000000. Flipping bit 40 gives a nonzero value. With the macro undefined, `signature` stays 0 throughout.

Source files
------------

// File: rtl/fuzz_chk_pkg.sv
// Shared types and constants for the fuzz response checker.
// The optional signature path is enabled by FUZZ_CHK_SIGNATURE_EN.
package fuzz_chk_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } chk_state_t;

  localparam int          SIG_W      = 32;
  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

endpackage

// File: rtl/fuzz_crc32_step.sv
// One full CRC-32 step: 32 MSB-first shifts, poly 0x04C11DB7,
// no reflection and no final XOR. Purely combinational.
module fuzz_crc32_step
  import fuzz_chk_pkg::*;
(
  input  logic [SIG_W-1:0] state_in,
  output logic [SIG_W-1:0] state_out
);

  // shift the whole word through the LFSR once
  always_comb begin
    logic [SIG_W-1:0] s;
    s = state_in;
    for (int i = 0; i < SIG_W; i++) begin
      if (s[SIG_W-1]) s = (s << 1) ^ CRC32_POLY;
      else            s = s << 1;
    end
    state_out = s;
  end

endmodule

// File: rtl/fuzz_response_checker.sv
// Response checker for the fuzz flow: compares netlist vs golden y,
// counts mismatches, records the first failing index and (optionally)
// folds every DUT response into a CRC-32 signature.
// Optional feature macro: FUZZ_CHK_SIGNATURE_EN (signature path built
// only when defined; otherwise signature is tied to zero).
//
// state  | meaning
// -------+---------------------------------------------
// S_IDLE | after reset, waiting for start
// S_RUN  | accepting samples until VEC_CNT have been seen
// S_DONE | verdict held until next start or reset
module fuzz_response_checker
  import fuzz_chk_pkg::*;
#(
  parameter int Y_W     = 635,
  parameter int VEC_CNT = 21,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [Y_W-1:0]   y_ref,
  input  logic [Y_W-1:0]   y_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [SIG_W-1:0] signature
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_CNT - 1);

  chk_state_t       state;
  logic [CNT_W-1:0] idx;
  logic             mismatch;
  logic             accept;
  logic             start_run;
  logic [CNT_W-1:0] cnt_next;

  // per-cycle decode of compare, accept and counter increment
  always_comb begin
    mismatch  = (y_ref != y_dut);
    accept    = (state == S_RUN) && sample_valid;
    start_run = (state != S_RUN) && start;
    cnt_next  = mismatch_cnt;
    if (mismatch && (mismatch_cnt != '1)) cnt_next = mismatch_cnt + 1'b1;
  end

  // run-control FSM with registered status and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '1;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_RUN;
            idx            <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '1;
          end
        end
        S_RUN: begin
          if (sample_valid) begin
            mismatch_cnt <= cnt_next;
            if (mismatch && (first_fail_idx == '1)) first_fail_idx <= idx;
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (cnt_next == '0);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FUZZ_CHK_SIGNATURE_EN
  localparam int N_CHUNK = (Y_W + SIG_W - 1) / SIG_W;

  logic [N_CHUNK*SIG_W-1:0]      y_pad;
  logic [N_CHUNK-1:0][SIG_W-1:0] chunk;
  logic [SIG_W-1:0]              fold;
  logic [SIG_W-1:0]              sig_next;

  // zero-extend y_dut at the MSB end to a whole number of words
  always_comb begin
    y_pad          = '0;
    y_pad[Y_W-1:0] = y_dut;
  end

  genvar g;
  generate
    for (g = 0; g < N_CHUNK; g++) begin : g_chunk
      assign chunk[g] = y_pad[g*SIG_W +: SIG_W];
    end
  endgenerate

  // XOR all words together into one 32-bit fold
  always_comb begin
    fold = '0;
    for (int i = 0; i < N_CHUNK; i++) fold = fold ^ chunk[i];
  end

  fuzz_crc32_step u_crc (
    .state_in  (signature ^ fold),
    .state_out (sig_next)
  );

  // signature register: seeded on run start, stepped per accepted sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            signature <= CRC32_INIT;
    else if (start_run) signature <= CRC32_INIT;
    else if (accept)    signature <= sig_next;
  end
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_fuzz_response_checker.sv
`timescale 1ns/1ps
module tb_fuzz_response_checker;
  localparam int Y_W     = 635;
  localparam int VEC_CNT = 21;
  localparam int CNT_W   = 16;
  localparam logic [CNT_W-1:0] NONE = '1;
`ifdef FUZZ_CHK_SIGNATURE_EN
  localparam logic [31:0] SIG_START = 32'hFFFFFFFF;
`else
  localparam logic [31:0] SIG_START = 32'h0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, sample_valid;
  logic [Y_W-1:0]   y_ref, y_dut;
  logic             busy, done, pass;
  logic [CNT_W-1:0] mismatch_cnt, first_fail_idx;
  logic [31:0]      signature;

  logic             start_s, valid_s;
  logic [Y_W-1:0]   y_ref_s, y_dut_s;
  logic             busy_s, done_s, pass_s;
  logic [CNT_W-1:0] cnt_s, ffi_s;
  logic [31:0]      sig_s;

  fuzz_response_checker #(.Y_W(Y_W), .VEC_CNT(VEC_CNT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .y_ref(y_ref), .y_dut(y_dut), .busy(busy), .done(done), .pass(pass),
    .mismatch_cnt(mismatch_cnt), .first_fail_idx(first_fail_idx),
    .signature(signature));

  fuzz_response_checker #(.Y_W(Y_W), .VEC_CNT(1), .CNT_W(CNT_W)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .sample_valid(valid_s),
    .y_ref(y_ref_s), .y_dut(y_dut_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .mismatch_cnt(cnt_s), .first_fail_idx(ffi_s), .signature(sig_s));

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ffi;
    logic [31:0]      sig;
    logic             last;
    logic             pass;
  } exp_t;

  exp_t             sb_q[$];
  logic [Y_W-1:0]   vecs[VEC_CNT];
  logic [CNT_W-1:0] m_cnt, m_ffi;
  logic [31:0]      m_sig;
  int               m_idx;
  int               cyc = 0;
  int               n_vec = 0, n_checks = 0, miscompares = 0;
  int               t0, clean_lat, gap_lat;

  function automatic logic [31:0] crc_ref(input logic [31:0] x);
    logic [31:0] s = x;
    for (int i = 0; i < 32; i++) s = s[31] ? ((s << 1) ^ 32'h04C11DB7) : (s << 1);
    return s;
  endfunction

  function automatic logic [31:0] fold_ref(input logic [Y_W-1:0] y);
    logic [639:0] p = '0;
    logic [31:0]  f = '0;
    p[Y_W-1:0] = y;
    for (int j = 0; j < 20; j++) f ^= p[j*32 +: 32];
    return f;
  endfunction

  function automatic logic [31:0] sig_ref(input logic [31:0] s, input logic [Y_W-1:0] y);
`ifdef FUZZ_CHK_SIGNATURE_EN
    return crc_ref(s ^ fold_ref(y));
`else
    return 32'h0 & s & fold_ref(y);
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_cnt", mismatch_cnt, 0);
    chk("rst_ffi", first_fail_idx, 16'hFFFF);
    chk("rst_sig", signature, SIG_START);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_cnt = '0; m_ffi = NONE; m_sig = SIG_START; m_idx = 0;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_cnt", mismatch_cnt, 0);
    chk("start_ffi", first_fail_idx, NONE);
    chk("start_sig", signature, SIG_START);
  endtask

  task automatic send(input logic [Y_W-1:0] r, input logic [Y_W-1:0] d);
    exp_t e;
    sample_valid = 1'b1; y_ref = r; y_dut = d;
    n_vec++;
    if (r != d) begin
      if (m_cnt != NONE) m_cnt = m_cnt + 1'b1;
      if (m_ffi == NONE) m_ffi = CNT_W'(m_idx);
    end
    m_sig  = sig_ref(m_sig, d);
    e.cnt  = m_cnt; e.ffi = m_ffi; e.sig = m_sig;
    e.last = (m_idx == VEC_CNT - 1);
    e.pass = e.last && (m_cnt == 0);
    m_idx++;
    sb_q.push_back(e);
    tick();
    sample_valid = 1'b0;
    e = sb_q.pop_front();
    chk("cnt", mismatch_cnt, e.cnt);
    chk("ffi", first_fail_idx, e.ffi);
    chk("sig", signature, e.sig);
    chk("done", done, e.last);
    chk("busy", busy, !e.last);
    chk("pass", pass, e.pass);
  endtask

  initial begin
    logic [639:0] t;
    logic [Y_W-1:0] v;
    rst = 1'b1; start = 0; sample_valid = 0; y_ref = '0; y_dut = '0;
    start_s = 0; valid_s = 0; y_ref_s = '0; y_dut_s = '0;
    for (int i = 0; i < VEC_CNT; i++) begin
      for (int j = 0; j < 20; j++) t[j*32 +: 32] = $urandom;
      vecs[i] = t[Y_W-1:0];
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    check_reset();

    // clean run
    t0 = cyc;
    do_start();
    for (int i = 0; i < VEC_CNT; i++) send(vecs[i], vecs[i]);
    clean_lat = cyc - t0;
    tick();
    chk("done_held", done, 1);
    chk("pass_held", pass, 1);

    // two mismatches on samples 3 and 7, restarted directly from DONE
    do_start();
    for (int i = 0; i < VEC_CNT; i++) begin
      v = vecs[i];
      if (i == 3 || i == 7) v[634] = ~v[634];
      send(vecs[i], v);
    end
    chk("mm_cnt", mismatch_cnt, 2);
    chk("mm_ffi", first_fail_idx, 3);

    // sample_valid ignored in DONE
    sample_valid = 1'b1; y_ref = vecs[0]; y_dut = ~vecs[0];
    tick();
    sample_valid = 1'b0;
    chk("done_ign_cnt", mismatch_cnt, 2);

    // gaps with a start pulse inside RUN
    t0 = cyc;
    do_start();
    for (int i = 0; i <= 10; i++) send(vecs[i], vecs[i]);
    for (int k = 0; k < 4; k++) begin
      start = (k == 1);
      y_dut = ~vecs[0];
      tick();
      start = 1'b0;
      chk("gap_busy", busy, 1);
      chk("gap_cnt", mismatch_cnt, 0);
      chk("gap_sig", signature, m_sig);
    end
    for (int i = 11; i < VEC_CNT; i++) send(vecs[i], vecs[i]);
    gap_lat = cyc - t0;
    chk("gap_latency", gap_lat, clean_lat + 4);

    // reset mid-run
    do_start();
    for (int i = 0; i < 5; i++) send(vecs[i], ~vecs[i]);
    rst = 1'b1;
    tick();
    check_reset();
    rst = 1'b0;
    tick();
    check_reset();
    do_start();
    for (int i = 0; i < VEC_CNT; i++) send(vecs[i], vecs[i]);
    chk("rr_pass", pass, 1);
    chk("rr_cnt", mismatch_cnt, 0);

    // signature on the single-vector instance
    chk("s_rst_sig", sig_s, SIG_START);
    start_s = 1'b1; tick(); start_s = 1'b0;
    v = '0; v[31:0] = 32'hFFFFFFFF;
    valid_s = 1'b1; y_ref_s = v; y_dut_s = v; n_vec++;
    tick();
    valid_s = 1'b0;
    chk("s_sig_ones", sig_s, 32'h0);
    chk("s_done", done_s, 1);
    chk("s_pass", pass_s, 1);
    chk("s_busy", busy_s, 0);
    start_s = 1'b1; tick(); start_s = 1'b0;
    v[40] = 1'b1;
    valid_s = 1'b1; y_ref_s = v; y_dut_s = v; n_vec++;
    tick();
    valid_s = 1'b0;
    chk("s_sig_b40", sig_s, sig_ref(SIG_START, v));
`ifdef FUZZ_CHK_SIGNATURE_EN
    chk("s_sig_nonzero", (sig_s != 32'h0), 1);
`endif
    chk("s_cnt", cnt_s, 0);
    chk("s_ffi", ffi_s, NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
